// File: rtl/boid_frame_sweeper_pkg.sv
// Shared definitions for the boid display path.
//   - screen geometry and framebuffer address width defaults
//   - sweep FSM state encoding
//   - saturating increment helper used by the status counters
package boid_disp_pkg;

  localparam int SCREEN_W_DEF = 640;
  localparam int SCREEN_H_DEF = 480;
  localparam int ADDR_W_DEF   = $clog2(SCREEN_W_DEF * SCREEN_H_DEF);

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    SWEEP,
    DRAIN
  } sweep_state_e;

  // Increment v, holding at 2^w-1 once reached.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
    logic [31:0] max_v;
    max_v = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
    return (v >= max_v) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/boid_frame_sweeper_if.sv
// Boid read port plus framebuffer write port.
//   boid_sel              slot being read (registered read, data next cycle)
//   boid_x/boid_y/active  data for the slot selected the previous cycle
//   fb_clear              one-cycle framebuffer clear pulse
//   fb_we/fb_addr         pixel write strobe and address (data is implicitly 1)
// master: the sweeper; slave: the BPU array / display RAM side.
interface boid_frame_sweeper_if #(
  parameter int SEL_W  = 7,
  parameter int X_W    = 10,
  parameter int Y_W    = 9,
  parameter int ADDR_W = 19
);
  logic [SEL_W-1:0]  boid_sel;
  logic [X_W-1:0]    boid_x;
  logic [Y_W-1:0]    boid_y;
  logic              boid_active;
  logic              fb_clear;
  logic              fb_we;
  logic [ADDR_W-1:0] fb_addr;

  modport master (
    output boid_sel, fb_clear, fb_we, fb_addr,
    input  boid_x, boid_y, boid_active
  );

  modport slave (
    input  boid_sel, fb_clear, fb_we, fb_addr,
    output boid_x, boid_y, boid_active
  );
endinterface

// File: rtl/boid_frame_sweeper_pixel_addr.sv
// boid_pixel_addr: registered bounds check and pixel address generation.
//   clock, resetn      clock and asynchronous active-low reset
//   in_valid           boid data on x/y/active belongs to a swept slot
//   x, y, active       boid position and live flag
//   pix_we, pix_addr   registered write strobe and y*SCREEN_W + x
//   skip               registered pulse: active boid off screen
module boid_pixel_addr #(
  parameter int X_W      = 10,
  parameter int Y_W      = 9,
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480,
  parameter int ADDR_W   = 19
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              in_valid,
  input  logic [X_W-1:0]    x,
  input  logic [Y_W-1:0]    y,
  input  logic              active,
  output logic              pix_we,
  output logic [ADDR_W-1:0] pix_addr,
  output logic              skip
);

  logic              in_bounds;
  logic [ADDR_W-1:0] addr_c;

  always_comb begin
    in_bounds = (32'(x) < 32'(SCREEN_W)) && (32'(y) < 32'(SCREEN_H));
    // Bounds check guarantees the product fits ADDR_W bits.
    addr_c    = ADDR_W'(y) * ADDR_W'(SCREEN_W) + ADDR_W'(x);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      pix_we   <= 1'b0;
      pix_addr <= '0;
      skip     <= 1'b0;
    end else begin
      pix_we <= in_valid & active & in_bounds;
      skip   <= in_valid & active & ~in_bounds;
      if (in_valid) pix_addr <= addr_c;
    end
  end

endmodule

// File: rtl/boid_frame_sweeper.sv
// boid_frame_sweeper: frame-rebuild engine for the boid framebuffer.
//   clock, resetn   clock and asynchronous active-low reset
//   frame_req       level request; a rising edge starts a rebuild
//   enable          gates new requests; a running sweep always completes
//   bus (master)    boid read port and framebuffer clear/write port
//   busy            sweep in progress
//   done            one-cycle sweep-complete pulse
//   skip_count      off-screen active boids in the last completed sweep
//   overrun_count   requests dropped since reset (saturating)
module boid_frame_sweeper
  import boid_disp_pkg::*;
#(
  parameter int NUM_BOIDS = 128,
  parameter int SEL_W     = $clog2(NUM_BOIDS),
  parameter int X_W       = 10,
  parameter int Y_W       = 9,
  parameter int SCREEN_W  = SCREEN_W_DEF,
  parameter int SCREEN_H  = SCREEN_H_DEF,
  parameter int ADDR_W    = $clog2(SCREEN_W * SCREEN_H),
  parameter int CNT_W     = 8
) (
  input  logic                   clock,
  input  logic                   resetn,
  input  logic                   frame_req,
  input  logic                   enable,
  boid_frame_sweeper_if.master   bus,
  output logic                   busy,
  output logic                   done,
  output logic [CNT_W-1:0]       skip_count,
  output logic [CNT_W-1:0]       overrun_count
);

  sweep_state_e      state_q, state_d;
  logic [SEL_W-1:0]  sel_q;
  logic              drain_q;
  logic              frame_req_q;
  logic              pending_q;
  logic              rd_valid_q;
  logic              done_q;
  logic [CNT_W-1:0]  skip_work_q;
  logic [CNT_W-1:0]  skip_cnt_q;
  logic [CNT_W-1:0]  overrun_q;

  logic              req;
  logic              last_slot;
  logic              start;
  logic              drain_end;
  logic              skip_flag;

  assign req       = frame_req & ~frame_req_q;
  assign last_slot = (sel_q == SEL_W'(NUM_BOIDS - 1));

  always_comb begin
    state_d   = state_q;
    start     = 1'b0;
    drain_end = 1'b0;
    case (state_q)
      IDLE: begin
        if ((req && enable) || pending_q) begin
          state_d = CLEAR;
          start   = 1'b1;
        end
      end
      CLEAR: state_d = SWEEP;
      SWEEP: if (last_slot) state_d = DRAIN;
      DRAIN: begin
        if (drain_q) begin
          state_d   = IDLE;
          drain_end = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      sel_q       <= '0;
      drain_q     <= 1'b0;
      frame_req_q <= 1'b1;
      pending_q   <= 1'b0;
      rd_valid_q  <= 1'b0;
      done_q      <= 1'b0;
      skip_work_q <= '0;
      skip_cnt_q  <= '0;
      overrun_q   <= '0;
    end else begin
      state_q     <= state_d;
      frame_req_q <= frame_req;
      done_q      <= drain_end;
      drain_q     <= (state_q == DRAIN) && !drain_q;
      rd_valid_q  <= (state_q == CLEAR) || (state_q == SWEEP);

      // Slot 0 is presented during CLEAR; the counter parks at 0 otherwise.
      if (((state_q == CLEAR) || (state_q == SWEEP)) && !last_slot)
        sel_q <= sel_q + 1'b1;
      else
        sel_q <= '0;

      if (start)
        pending_q <= 1'b0;
      else if ((state_q != IDLE) && req && enable) begin
        if (!pending_q) pending_q <= 1'b1;
        else            overrun_q <= CNT_W'(sat_inc(32'(overrun_q), CNT_W));
      end

      if (state_q == CLEAR)
        skip_work_q <= '0;
      else if (skip_flag)
        skip_work_q <= CNT_W'(sat_inc(32'(skip_work_q), CNT_W));

      // The last slot's skip flag lands in the final DRAIN cycle, so fold it
      // in here to make skip_count valid in the same cycle as done.
      if (drain_end)
        skip_cnt_q <= skip_flag ? CNT_W'(sat_inc(32'(skip_work_q), CNT_W)) : skip_work_q;
    end
  end

  boid_pixel_addr #(
    .X_W      (X_W),
    .Y_W      (Y_W),
    .SCREEN_W (SCREEN_W),
    .SCREEN_H (SCREEN_H),
    .ADDR_W   (ADDR_W)
  ) u_pixel_addr (
    .clock    (clock),
    .resetn   (resetn),
    .in_valid (rd_valid_q),
    .x        (bus.boid_x),
    .y        (bus.boid_y),
    .active   (bus.boid_active),
    .pix_we   (bus.fb_we),
    .pix_addr (bus.fb_addr),
    .skip     (skip_flag)
  );

  assign bus.boid_sel = sel_q;
  assign bus.fb_clear = (state_q == CLEAR);
  assign busy         = (state_q != IDLE);
  assign done         = done_q;
  assign skip_count   = skip_cnt_q;
  assign overrun_count = overrun_q;

endmodule
